// File: rtl/serial_mag_comp.sv
// Bit-serial MSB-first magnitude comparator: accepts one bit pair per valid beat
// and reports A>B, A<B or A==B, plus the first differing bit position, after WIDTH beats.
module serial_mag_comp #(
    parameter int WIDTH = 8,
    localparam int IW = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          bit_valid,
    input  logic          a_bit,
    input  logic          b_bit,
    output logic          busy,
    output logic          done,
    output logic          yg,
    output logic          yl,
    output logic          ye,
    output logic [IW-1:0] diff_idx
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [IW:0]   CNT_LAST = (IW + 1)'(WIDTH - 1);
    localparam logic [IW-1:0] IDX_MSB  = IW'(WIDTH - 1);

    state_t        state_r;
    state_t        state_s;
    logic [IW:0]   cnt_r;
    logic          decided_r;
    logic          gt_r;

    logic          last_s;
    logic          bit_diff_s;
    logic [IW-1:0] pos_s;
    logic          decided_final_s;
    logic          gt_final_s;

    // Beat decode: cnt never exceeds WIDTH-1 in SHIFT, so its low IW bits give the position.
    always_comb begin
        last_s          = (cnt_r == CNT_LAST);
        bit_diff_s      = a_bit ^ b_bit;
        pos_s           = IDX_MSB - cnt_r[IW-1:0];
        decided_final_s = decided_r | bit_diff_s;
        if (decided_r) begin
            gt_final_s = gt_r;
        end else begin
            gt_final_s = a_bit;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (bit_valid && last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Comparison datapath and registered outputs; results hold in IDLE until the next start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r     <= '0;
            decided_r <= 1'b0;
            gt_r      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            yg        <= 1'b0;
            yl        <= 1'b0;
            ye        <= 1'b0;
            diff_idx  <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        cnt_r     <= '0;
                        decided_r <= 1'b0;
                        gt_r      <= 1'b0;
                        busy      <= 1'b1;
                        yg        <= 1'b0;
                        yl        <= 1'b0;
                        ye        <= 1'b0;
                        diff_idx  <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (bit_valid) begin
                        if (!decided_r && bit_diff_s) begin
                            decided_r <= 1'b1;
                            gt_r      <= a_bit;
                            diff_idx  <= pos_s;
                        end
                        cnt_r <= cnt_r + {{IW{1'b0}}, 1'b1};
                        if (last_s) begin
                            done <= 1'b1;
                            if (decided_final_s) begin
                                yg <= gt_final_s;
                                yl <= ~gt_final_s;
                            end else begin
                                ye <= 1'b1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                end
                default: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_mag_comp.sv
// Self-checking bench for serial_mag_comp: WIDTH=4 and WIDTH=8 instances checked every
// cycle against an operand-level model, plus hand-computed literal expectations.
module tb_serial_mag_comp;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] start = 2'b00;
    logic [1:0] bvalid = 2'b00;
    logic [1:0] abit = 2'b00;
    logic [1:0] bbit = 2'b00;
    logic [1:0] busy, done, yg, yl, ye;
    logic [1:0] idx4;
    logic [2:0] idx8;

    int n_total = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    typedef struct {
        int          phase;   // 0 idle, 1 collecting bits, 2 result cycle
        int          beats;
        logic [63:0] a;
        logic [63:0] b;
        logic        busy;
        logic        done;
        logic        yg;
        logic        yl;
        logic        ye;
        int          idx;
    } model_t;

    model_t m[2];
    int     wid[2] = '{4, 8};

    serial_mag_comp #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .bit_valid(bvalid[0]),
        .a_bit(abit[0]), .b_bit(bbit[0]), .busy(busy[0]), .done(done[0]),
        .yg(yg[0]), .yl(yl[0]), .ye(ye[0]), .diff_idx(idx4)
    );

    serial_mag_comp #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .bit_valid(bvalid[1]),
        .a_bit(abit[1]), .b_bit(bbit[1]), .busy(busy[1]), .done(done[1]),
        .yg(yg[1]), .yl(yl[1]), .ye(ye[1]), .diff_idx(idx8)
    );

    always #5 clk = ~clk;

    // Operand-level model: collect the whole operands, then compare them as integers.
    function automatic model_t step(model_t cur, int w, logic rn, logic st, logic v,
                                    logic ab, logic bb);
        model_t n;
        n = cur;
        if (!rn) begin
            n = '{default: 0};
            return n;
        end
        case (cur.phase)
            0: begin
                n.done = 1'b0;
                if (st) begin
                    n.phase = 1; n.beats = 0; n.a = '0; n.b = '0;
                    n.yg = 1'b0; n.yl = 1'b0; n.ye = 1'b0; n.idx = 0; n.busy = 1'b1;
                end
            end
            1: begin
                if (v) begin
                    n.a = {cur.a[62:0], ab};
                    n.b = {cur.b[62:0], bb};
                    n.beats = cur.beats + 1;
                    if (n.beats == w) begin
                        n.phase = 2;
                        n.done = 1'b1;
                        n.yg = (n.a > n.b);
                        n.yl = (n.a < n.b);
                        n.ye = (n.a == n.b);
                        n.idx = 0;
                        for (int k = 0; k < w; k++) begin
                            if (n.a[k] != n.b[k]) n.idx = k;
                        end
                    end
                end
            end
            2: begin
                n.phase = 0; n.done = 1'b0; n.busy = 1'b0;
            end
            default: n.phase = 0;
        endcase
        return n;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            m[i] <= step(m[i], wid[i], rst_n, start[i], bvalid[i], abit[i], bbit[i]);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dut_idx(int i);
        if (i == 0) return int'(idx4);
        return int'(idx8);
    endfunction

    // Per-cycle comparison of both DUTs against the model, away from the rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("busy%0d", i), busy[i], m[i].busy);
                chk($sformatf("done%0d", i), done[i], m[i].done);
                chk($sformatf("yg%0d", i), yg[i], m[i].yg);
                chk($sformatf("yl%0d", i), yl[i], m[i].yl);
                chk($sformatf("ye%0d", i), ye[i], m[i].ye);
                if (m[i].phase != 1) begin
                    chk($sformatf("diff_idx%0d", i), dut_idx(i), m[i].idx);
                end
            end
        end
    end

    // One cycle of stimulus: drive after a falling edge, hold until the next falling edge.
    task automatic cyc(input int i, input logic st, input logic v, input logic a, input logic b);
        start[i] = st; bvalid[i] = v; abit[i] = a; bbit[i] = b;
        @(negedge clk);
    endtask

    // Full comparison; returns at the falling edge where done must be visible.
    task automatic run_cmp(input int i, input int w, input logic [63:0] av, input logic [63:0] bv,
                           input int stall_after, input int stall_len, input int glitch_at);
        cyc(i, 1'b1, 1'b0, 1'b0, 1'b0);
        chk($sformatf("start_busy%0d", i), busy[i], 1'b1);
        chk($sformatf("start_clr%0d", i), {yg[i], yl[i], ye[i]}, 3'b000);
        for (int j = 0; j < w; j++) begin
            cyc(i, (j == glitch_at), 1'b1, av[w-1-j], bv[w-1-j]);
            if (j == stall_after) begin
                for (int s = 0; s < stall_len; s++) begin
                    cyc(i, 1'b0, 1'b0, ~av[w-1-j], bv[w-1-j]);
                    chk($sformatf("stall_busy%0d", i), busy[i], 1'b1);
                    chk($sformatf("stall_nodone%0d", i), done[i], 1'b0);
                end
            end
        end
        chk($sformatf("done_lat%0d", i), done[i], 1'b1);
    endtask

    task automatic expect_res(input string name, input int i, input logic [2:0] gle, input int idx);
        chk({name, "_gle"}, {yg[i], yl[i], ye[i]}, gle);
        chk({name, "_idx"}, dut_idx(i), idx);
        chk({name, "_model_gle"}, {m[i].yg, m[i].yl, m[i].ye}, gle);
        chk({name, "_model_idx"}, m[i].idx, idx);
    endtask

    initial begin
        m[0] = '{default: 0};
        m[1] = '{default: 0};
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_out4", {busy[0], done[0], yg[0], yl[0], ye[0], idx4}, 7'd0);
        chk("rst_out8", {busy[1], done[1], yg[1], yl[1], ye[1], idx8}, 8'd0);
        rst_n = 1'b1;
        cyc(0, 1'b0, 1'b0, 1'b0, 1'b0);

        // A=1010 > B=1001, decided at bit 1
        run_cmp(0, 4, 64'hA, 64'h9, -1, 0, -1);
        expect_res("t1", 0, 3'b100, 1);
        cyc(0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1_done_pulse", done[0], 1'b0);

        // MSB decides A<B; later A>B bits ignored
        run_cmp(0, 4, 64'h7, 64'h8, -1, 0, -1);
        expect_res("t2", 0, 3'b010, 3);
        cyc(0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Equal operands with a 3-cycle stall between beats 2 and 3
        run_cmp(0, 4, 64'h6, 64'h6, 1, 3, -1);
        expect_res("t3", 0, 3'b001, 0);
        cyc(0, 1'b0, 1'b0, 1'b0, 1'b0);

        // bit_valid in IDLE ignored; result holds
        for (int k = 0; k < 3; k++) cyc(0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("hold_busy", busy[0], 1'b0);
        expect_res("hold", 0, 3'b001, 0);

        // start pulsed mid-SHIFT is ignored: A=0011 < B=0101 at bit 2
        run_cmp(0, 4, 64'h3, 64'h5, -1, 0, 1);
        expect_res("t4", 0, 3'b010, 2);
        cyc(0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset after 2 beats: everything cleared, no done
        cyc(0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(0, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(0, 1'b0, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b0;
        cyc(0, 1'b0, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        chk("mid_rst_out", {busy[0], done[0], yg[0], yl[0], ye[0], idx4}, 7'd0);
        for (int k = 0; k < 4; k++) begin
            cyc(0, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("mid_rst_nodone", done[0], 1'b0);
        end
        run_cmp(0, 4, 64'hC, 64'hD, -1, 0, -1);
        expect_res("t5", 0, 3'b010, 0);
        cyc(0, 1'b0, 1'b0, 1'b0, 1'b0);

        // WIDTH=8 back-to-back: issue interval of 10 cycles
        run_cmp(1, 8, 64'hFF, 64'hFE, -1, 0, -1);
        expect_res("t6a", 1, 3'b100, 0);
        cyc(1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_cmp(1, 8, 64'h00, 64'h80, -1, 0, -1);
        expect_res("t6b", 1, 3'b010, 7);
        cyc(1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t6_idle_busy", busy[1], 1'b0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_mag_comp.md
Name: serial_mag_comp

Overview:
- Bit-serial magnitude comparator, MSB-first; one bit pair per accepted beat.
- Applies the 1-bit greater/less/equal decision per beat and latches the first differing bit.
- Reports greater, lesser or equal for two WIDTH-bit operands after all WIDTH beats.
- Sits downstream of serializers or shift registers that stream operand bits.

Parameters:
- WIDTH, 8, operand length in bits; legal range 2..64.
- IW, $clog2(WIDTH), derived width of the index and count fields; not for override.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- start  input  1  begins a comparison; sampled only in IDLE.
- bit_valid  input  1  a_bit/b_bit valid this cycle; sampled only in SHIFT.
- a_bit  input  1  current bit of operand A, MSB first.
- b_bit  input  1  current bit of operand B, MSB first.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle pulse; result valid.
- yg  output  1  A > B.
- yl  output  1  A < B.
- ye  output  1  A == B.
- diff_idx  output  IW  bit position (WIDTH-1 = MSB) of the first differing bit; 0 when equal.

Behaviour:
- Clocking: all state and outputs are registered and change only on the clk rising edge. Reset is synchronous: rst_n=0 at an edge takes priority over everything.
- Reset values: state=IDLE, busy=0, done=0, yg=0, yl=0, ye=0, diff_idx=0, internal cnt=0, decided=0.
- IDLE:
  - start=1 -> SHIFT. Clear cnt, decided, yg, yl, ye and diff_idx; busy=1 from the next cycle.
  - bit_valid is ignored.
- SHIFT, only when bit_valid=1:
  - Bit position is WIDTH-1-cnt.
  - If decided=0 and a_bit!=b_bit: set decided=1, gt=a_bit, diff_idx=WIDTH-1-cnt.
  - Once decided=1, later bits never change gt or diff_idx.
  - cnt increments. When cnt==WIDTH-1 and bit_valid=1, go to DONE.
  - In the same edge, register the result: decided=0 gives ye=1; otherwise yg=gt and yl=~gt.
- SHIFT with bit_valid=0: stall; nothing changes. A stall may last any length.
- start during SHIFT or DONE is ignored. No re-arm, no restart.
- DONE: lasts exactly 1 cycle with done=1 and busy=1, then goes to IDLE. done=0 in every other state.
- Result hold: yg, yl, ye and diff_idx hold their value in IDLE until the next accepted start clears them.
- Exactly one of yg, yl, ye is 1 while done=1.
- Latency with continuous bit_valid:
  - start sampled at edge k.
  - Bits sampled at edges k+1 .. k+WIDTH.
  - done high during the cycle after edge k+WIDTH.
  - Total WIDTH+1 edges.
- Back-to-back operation: start asserted in the cycle after done (state IDLE) is accepted. Minimum issue interval is WIDTH+2 cycles.
- Reset mid-operation (SHIFT or DONE): returns to IDLE with reset values; the partial result is discarded and no done is produced.
- Counter cnt is IW+1 bits wide and never wraps within a comparison.

Test Plan:
- Reset, then WIDTH=4, start, stream A=1010 and B=1001 continuously -> done exactly 5 edges after start; yg=1, yl=0, ye=0, diff_idx=1.
- A=0111, B=1000 -> yl=1, diff_idx=3. The MSB decides and later A>B bits are ignored.
- A=B=0110, with bit_valid low for 3 cycles between beats 2 and 3 -> ye=1, diff_idx=0; done arrives 3 cycles later than with continuous beats. Check busy stays 1 throughout the stall.
- Pulse start mid-SHIFT and bit_valid while in IDLE -> no effect: cnt, result and timing unchanged. Results hold in IDLE until the next start clears them to 0.
- Pull rst_n low after 2 beats -> next edge gives IDLE, all outputs 0, and no done. A new comparison after reset behaves normally.
- WIDTH=8, back-to-back: A=0xFF/B=0xFE, then start in the cycle after done with A=0x00/B=0x80 -> yg=1 with diff_idx=0, then yl=1 with diff_idx=7; issue interval is 10 cycles.
